// File: rtl/decode_stage.sv
// Decode stage: field extraction, register scoreboard for RAW/WAW interlock,
// write-back forwarding, and a single output register toward execute.
module decode_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_i_valid,
    input  logic [31:0]     fetch_i_instr,
    input  logic [XLEN-1:0] fetch_i_pc,
    output logic            decode_o_ready,
    output logic [4:0]      decode_o_read_rs1,
    output logic [4:0]      decode_o_read_rs2,
    input  logic [XLEN-1:0] regfile_i_valA,
    input  logic [XLEN-1:0] regfile_i_valB,
    input  logic            write_back_i_reg_wen,
    input  logic [4:0]      write_back_i_reg_rd,
    input  logic [XLEN-1:0] write_back_i_reg_data,
    input  logic            flush_i,
    input  logic            execute_i_ready,
    output logic            decode_o_valid,
    output logic [XLEN-1:0] decode_o_pc,
    output logic [31:0]     decode_o_instr,
    output logic [XLEN-1:0] decode_o_valA,
    output logic [XLEN-1:0] decode_o_valB,
    output logic [4:0]      decode_o_rd,
    output logic            decode_o_reg_wen
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpReg32  = 7'b0111011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2, reg_wen;
    logic            out_hit_rs1, out_hit_rs2, out_hit_rd;
    logic            wb_hit_rs1, wb_hit_rs2;
    logic            haz_rs1, haz_rs2, haz_waw, hazard;
    logic            ready, accept, fire;
    logic [XLEN-1:0] opa, opb;

    logic [31:0]     busy_q, busy_d;
    logic            valid_q;
    logic [XLEN-1:0] pc_q, vala_q, valb_q;
    logic [31:0]     instr_q;
    logic [4:0]      rd_q;
    logic            reg_wen_q;

    always_comb begin
        opcode = fetch_i_instr[6:0];
        rd     = fetch_i_instr[11:7];
        rs1    = fetch_i_instr[19:15];
        rs2    = fetch_i_instr[24:20];

        uses_rs1 = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
        uses_rs2 = (opcode == OpReg) || (opcode == OpReg32) || (opcode == OpStore) ||
                   (opcode == OpBranch);
        reg_wen  = !((opcode == OpStore) || (opcode == OpBranch)) && (rd != 5'd0);

        out_hit_rs1 = valid_q && reg_wen_q && (rd_q == rs1);
        out_hit_rs2 = valid_q && reg_wen_q && (rd_q == rs2);
        out_hit_rd  = valid_q && reg_wen_q && (rd_q == rd);
        wb_hit_rs1  = write_back_i_reg_wen && (write_back_i_reg_rd == rs1) && (rs1 != 5'd0);
        wb_hit_rs2  = write_back_i_reg_wen && (write_back_i_reg_rd == rs2) && (rs2 != 5'd0);

        // A same-cycle write-back resolves a scoreboard hit, never an output-register hit.
        haz_rs1 = uses_rs1 && (rs1 != 5'd0) && (out_hit_rs1 || (busy_q[rs1] && !wb_hit_rs1));
        haz_rs2 = uses_rs2 && (rs2 != 5'd0) && (out_hit_rs2 || (busy_q[rs2] && !wb_hit_rs2));
        haz_waw = reg_wen && (busy_q[rd] || out_hit_rd);
        hazard  = haz_rs1 || haz_rs2 || haz_waw;

        fire   = valid_q && execute_i_ready;
        ready  = !rst && !flush_i && !hazard && (!valid_q || execute_i_ready);
        accept = fetch_i_valid && ready;

        opa = '0;
        if (uses_rs1) opa = wb_hit_rs1 ? write_back_i_reg_data : regfile_i_valA;
        opb = '0;
        if (uses_rs2) opb = wb_hit_rs2 ? write_back_i_reg_data : regfile_i_valB;

        // Set after clear so a same-index set wins; a flushed instruction never sets.
        busy_d = busy_q;
        if (write_back_i_reg_wen && (write_back_i_reg_rd != 5'd0)) begin
            busy_d[write_back_i_reg_rd] = 1'b0;
        end
        if (fire && reg_wen_q && !flush_i) busy_d[rd_q] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            vala_q    <= '0;
            valb_q    <= '0;
            rd_q      <= '0;
            reg_wen_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q   <= 1'b1;
                pc_q      <= fetch_i_pc;
                instr_q   <= fetch_i_instr;
                vala_q    <= opa;
                valb_q    <= opb;
                rd_q      <= rd;
                reg_wen_q <= reg_wen;
            end else if (fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign decode_o_ready    = ready;
    assign decode_o_read_rs1 = rs1;
    assign decode_o_read_rs2 = rs2;
    assign decode_o_valid    = valid_q;
    assign decode_o_pc       = pc_q;
    assign decode_o_instr    = instr_q;
    assign decode_o_valA     = vala_q;
    assign decode_o_valB     = valb_q;
    assign decode_o_rd       = rd_q;
    assign decode_o_reg_wen  = reg_wen_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction sequences push expected
// outputs; a negedge monitor pops and compares on every output fire.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_i_valid;
    logic [31:0] fetch_i_instr;
    logic [63:0] fetch_i_pc;
    logic        decode_o_ready;
    logic [4:0]  decode_o_read_rs1, decode_o_read_rs2;
    logic [63:0] regfile_i_valA, regfile_i_valB;
    logic        write_back_i_reg_wen;
    logic [4:0]  write_back_i_reg_rd;
    logic [63:0] write_back_i_reg_data;
    logic        flush_i;
    logic        execute_i_ready;
    logic        decode_o_valid;
    logic [63:0] decode_o_pc, decode_o_valA, decode_o_valB;
    logic [31:0] decode_o_instr;
    logic [4:0]  decode_o_rd;
    logic        decode_o_reg_wen;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_i_valid        (fetch_i_valid),
        .fetch_i_instr        (fetch_i_instr),
        .fetch_i_pc           (fetch_i_pc),
        .decode_o_ready       (decode_o_ready),
        .decode_o_read_rs1    (decode_o_read_rs1),
        .decode_o_read_rs2    (decode_o_read_rs2),
        .regfile_i_valA       (regfile_i_valA),
        .regfile_i_valB       (regfile_i_valB),
        .write_back_i_reg_wen (write_back_i_reg_wen),
        .write_back_i_reg_rd  (write_back_i_reg_rd),
        .write_back_i_reg_data(write_back_i_reg_data),
        .flush_i              (flush_i),
        .execute_i_ready      (execute_i_ready),
        .decode_o_valid       (decode_o_valid),
        .decode_o_pc          (decode_o_pc),
        .decode_o_instr       (decode_o_instr),
        .decode_o_valA        (decode_o_valA),
        .decode_o_valB        (decode_o_valB),
        .decode_o_rd          (decode_o_rd),
        .decode_o_reg_wen     (decode_o_reg_wen)
    );

    // Register file model: x0 reads 0, xN holds N<<8 except x3 = 1.
    logic [63:0] rf [32];
    assign regfile_i_valA = (decode_o_read_rs1 == 5'd0) ? 64'd0 : rf[decode_o_read_rs1];
    assign regfile_i_valB = (decode_o_read_rs2 == 5'd0) ? 64'd0 : rf[decode_o_read_rs2];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0000000, rs2, rs1, 3'b010, 5'b00000, 7'b0100011};
    endfunction

    task automatic push(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic wen);
        exp_t e;
        e.pc = pc; e.instr = instr; e.a = a; e.b = b; e.rd = rd; e.wen = wen;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
        fetch_i_valid = 1'b1;
        fetch_i_instr = instr;
        fetch_i_pc    = pc;
    endtask

    task automatic idle();
        fetch_i_valid = 1'b0;
    endtask

    task automatic wb_clear(input logic [4:0] rd);
        write_back_i_reg_wen  = 1'b1;
        write_back_i_reg_rd   = rd;
        write_back_i_reg_data = 64'hCAFE;
        tick();
        write_back_i_reg_wen  = 1'b0;
    endtask

    // Monitor: every output fire must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && decode_o_valid && execute_i_ready && !flush_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got pc %h want none", decode_o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_pc", decode_o_pc, e.pc);
                check("out_instr", {32'd0, decode_o_instr}, {32'd0, e.instr});
                check("out_valA", decode_o_valA, e.a);
                check("out_valB", decode_o_valB, e.b);
                check("out_rd", {59'd0, decode_o_rd}, {59'd0, e.rd});
                check("out_reg_wen", {63'd0, decode_o_reg_wen}, {63'd0, e.wen});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] i_tmp;
        for (int i = 0; i < 32; i++) rf[i] = 64'(i) << 8;
        rf[3] = 64'h1;
        rst = 1'b1;
        fetch_i_valid = 1'b0; fetch_i_instr = '0; fetch_i_pc = '0;
        write_back_i_reg_wen = 1'b0; write_back_i_reg_rd = '0; write_back_i_reg_data = '0;
        flush_i = 1'b0; execute_i_ready = 1'b1;

        // Reset
        sample();
        check("ready_in_reset", {63'd0, decode_o_ready}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        sample();
        check("rst_valid", {63'd0, decode_o_valid}, 64'd0);
        check("rst_pc", decode_o_pc, 64'd0);
        check("rst_busy", {32'd0, dut.busy_q}, 64'd0);
        check("rst_ready", {63'd0, decode_o_ready}, 64'd1);
        tick();

        // x0 / store stream: no writes, no stalls, one per cycle
        offer(enc_sw(5'd0, 5'd0), 64'h100);
        sample();
        check("stream_ready0", {63'd0, decode_o_ready}, 64'd1);
        push(64'h100, enc_sw(5'd0, 5'd0), 64'd0, 64'd0, 5'd0, 1'b0);
        tick();
        offer(enc_addi(5'd0, 5'd0, 12'd1), 64'h104);
        sample();
        check("stream_ready1", {63'd0, decode_o_ready}, 64'd1);
        push(64'h104, enc_addi(5'd0, 5'd0, 12'd1), 64'd0, 64'd0, 5'd0, 1'b0);
        tick();
        offer(enc_sw(5'd0, 5'd0), 64'h108);
        sample();
        check("stream_ready2", {63'd0, decode_o_ready}, 64'd1);
        push(64'h108, enc_sw(5'd0, 5'd0), 64'd0, 64'd0, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        sample();
        check("stream_busy", {32'd0, dut.busy_q}, 64'd0);
        tick();

        // Forwarding: write-back x3 while ADD x4,x3,x3 is offered
        offer(enc_add(5'd4, 5'd3, 5'd3), 64'h200);
        write_back_i_reg_wen = 1'b1; write_back_i_reg_rd = 5'd3;
        write_back_i_reg_data = 64'hDEAD;
        sample();
        check("fwd_read_rs1", {59'd0, decode_o_read_rs1}, 64'd3);
        check("fwd_read_rs2", {59'd0, decode_o_read_rs2}, 64'd3);
        check("fwd_ready", {63'd0, decode_o_ready}, 64'd1);
        push(64'h200, enc_add(5'd4, 5'd3, 5'd3), 64'hDEAD, 64'hDEAD, 5'd4, 1'b1);
        tick();
        write_back_i_reg_wen = 1'b0;
        idle();
        tick();
        sample();
        check("fwd_busy", {32'd0, dut.busy_q}, 64'h10);
        wb_clear(5'd4);

        // RAW stall on x1 until its write-back
        offer(enc_addi(5'd1, 5'd0, 12'd5), 64'h300);
        sample();
        check("raw_ready_addi", {63'd0, decode_o_ready}, 64'd1);
        push(64'h300, enc_addi(5'd1, 5'd0, 12'd5), 64'd0, 64'd0, 5'd1, 1'b1);
        tick();
        offer(enc_add(5'd2, 5'd1, 5'd0), 64'h304);
        sample();
        check("raw_stall_outreg", {63'd0, decode_o_ready}, 64'd0);
        tick();
        sample();
        check("raw_stall_busy", {63'd0, decode_o_ready}, 64'd0);
        check("raw_busy1", {32'd0, dut.busy_q}, 64'h2);
        tick();
        write_back_i_reg_wen = 1'b1; write_back_i_reg_rd = 5'd1;
        write_back_i_reg_data = 64'h55;
        sample();
        check("raw_release", {63'd0, decode_o_ready}, 64'd1);
        push(64'h304, enc_add(5'd2, 5'd1, 5'd0), 64'h55, 64'd0, 5'd2, 1'b1);
        tick();
        write_back_i_reg_wen = 1'b0;
        idle();
        tick();
        sample();
        check("raw_busy2", {32'd0, dut.busy_q}, 64'h4);
        wb_clear(5'd2);

        // Backpressure: four held cycles
        offer(enc_addi(5'd9, 5'd0, 12'd7), 64'h400);
        push(64'h400, enc_addi(5'd9, 5'd0, 12'd7), 64'd0, 64'd0, 5'd9, 1'b1);
        tick();
        execute_i_ready = 1'b0;
        offer(enc_addi(5'd10, 5'd0, 12'd1), 64'h404);
        i_tmp = enc_addi(5'd9, 5'd0, 12'd7);
        for (int k = 0; k < 4; k++) begin
            sample();
            check("bp_ready", {63'd0, decode_o_ready}, 64'd0);
            check("bp_valid", {63'd0, decode_o_valid}, 64'd1);
            check("bp_pc", decode_o_pc, 64'h400);
            check("bp_instr", {32'd0, decode_o_instr}, {32'd0, i_tmp});
            check("bp_rd", {59'd0, decode_o_rd}, 64'd9);
            tick();
        end
        execute_i_ready = 1'b1;
        sample();
        check("bp_release_ready", {63'd0, decode_o_ready}, 64'd1);
        push(64'h404, enc_addi(5'd10, 5'd0, 12'd1), 64'd0, 64'd0, 5'd10, 1'b1);
        tick();
        idle();
        tick();
        sample();
        check("bp_busy", {32'd0, dut.busy_q}, 64'h600);
        wb_clear(5'd9);
        wb_clear(5'd10);

        // Flush of held ADDI x7 leaves no scoreboard bit
        execute_i_ready = 1'b0;
        offer(enc_addi(5'd7, 5'd0, 12'd3), 64'h500);
        sample();
        check("fl_accept", {63'd0, decode_o_ready}, 64'd1);
        tick();
        idle();
        flush_i = 1'b1;
        sample();
        check("fl_ready", {63'd0, decode_o_ready}, 64'd0);
        tick();
        flush_i = 1'b0;
        execute_i_ready = 1'b1;
        offer(enc_add(5'd8, 5'd7, 5'd0), 64'h504);
        sample();
        check("fl_valid", {63'd0, decode_o_valid}, 64'd0);
        check("fl_busy", {32'd0, dut.busy_q}, 64'd0);
        check("fl_next_ready", {63'd0, decode_o_ready}, 64'd1);
        push(64'h504, enc_add(5'd8, 5'd7, 5'd0), 64'h700, 64'd0, 5'd8, 1'b1);
        tick();
        idle();
        tick();
        wb_clear(5'd8);

        // Reset while stalled on busy x5
        offer(enc_addi(5'd5, 5'd0, 12'd1), 64'h600);
        push(64'h600, enc_addi(5'd5, 5'd0, 12'd1), 64'd0, 64'd0, 5'd5, 1'b1);
        tick();
        idle();
        tick();
        offer(enc_add(5'd6, 5'd5, 5'd0), 64'h604);
        sample();
        check("rs_busy5", {32'd0, dut.busy_q}, 64'h20);
        check("rs_stall", {63'd0, decode_o_ready}, 64'd0);
        tick();
        rst = 1'b1;
        sample();
        check("rs_ready_rst", {63'd0, decode_o_ready}, 64'd0);
        tick();
        rst = 1'b0;
        sample();
        check("rs_valid", {63'd0, decode_o_valid}, 64'd0);
        check("rs_busy", {32'd0, dut.busy_q}, 64'd0);
        check("rs_ready", {63'd0, decode_o_ready}, 64'd1);
        push(64'h604, enc_add(5'd6, 5'd5, 5'd0), 64'h500, 64'd0, 5'd6, 1'b1);
        tick();

        // LUI: rs1 field aliases x6 (in output reg) but is unused, operand captured as 0
        offer(32'h000305B7, 64'h608);
        sample();
        check("lui_ready", {63'd0, decode_o_ready}, 64'd1);
        push(64'h608, 32'h000305B7, 64'd0, 64'd0, 5'd11, 1'b1);
        tick();
        idle();
        tick();
        tick();
        sample();
        check("end_busy", {32'd0, dut.busy_q}, 64'h840);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, register/operand/PC width.
REQ-002 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have fetch_i_valid  in  1  instruction offered by fetch.
REQ-005 SHALL have fetch_i_instr  in  32  RV64 instruction word.
REQ-006 SHALL have fetch_i_pc  in  XLEN  PC of offered instruction.
REQ-007 SHALL have decode_o_ready  out  1  decode accepts offered instruction this cycle.
REQ-008 SHALL have decode_o_read_rs1 / decode_o_read_rs2  out  5 each  regfile read addresses, combinational from fetch_i_instr[19:15] / [24:20].
REQ-009 SHALL have regfile_i_valA / regfile_i_valB  in  XLEN each  regfile read data (x0 reads 0).
REQ-010 SHALL have write_back_i_reg_wen, write_back_i_reg_rd, write_back_i_reg_data  in  1/5/XLEN  write-back port, snooped.
REQ-011 SHALL have flush_i  in  1  kill instruction held in output register.
REQ-012 SHALL have execute_i_ready  in  1  execute accepts output this cycle.
REQ-013 SHALL have decode_o_valid  out  1; decode_o_pc  out  XLEN; decode_o_instr  out  32; decode_o_valA / decode_o_valB  out  XLEN; decode_o_rd  out  5; decode_o_reg_wen  out  1.

Function
REQ-014 SHALL decode rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
REQ-015 SHALL set uses_rs1 for all opcodes except 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL); uses_rs2 only for 0110011, 0111011, 0100011, 1100011.
REQ-016 SHALL set reg_wen = 1 unless opcode is 0100011 (STORE) or 1100011 (BRANCH), or rd==0.
REQ-017 SHALL keep a scoreboard busy[31:1] (busy[0] constant 0) marking registers with an in-flight write past decode.
REQ-018 SHALL set busy[rd] on output fire (decode_o_valid && execute_i_ready) when decode_o_reg_wen=1.
REQ-019 SHALL clear busy[rd] when write_back_i_reg_wen=1 and rd!=0; same-cycle set and clear of the same index: set wins.
REQ-020 SHALL flag source hazard for rsN when usesN && rsN!=0 && (busy[rsN] || (decode_o_valid && decode_o_reg_wen && decode_o_rd==rsN)), except when write-back this cycle writes rsN and the output-register term is false.
REQ-021 SHALL flag WAW hazard when reg_wen && (busy[rd] || (decode_o_valid && decode_o_reg_wen && decode_o_rd==rd)).
REQ-022 SHALL drive decode_o_ready = !flush_i && !hazard && (!decode_o_valid || execute_i_ready); ready may depend on fetch_i_instr, which fetch holds stable while valid.
REQ-023 SHALL accept (fetch_i_valid && decode_o_ready) and load output register next edge: 1-cycle latency.
REQ-024 SHALL forward write_back_i_reg_data instead of regfile data for any source whose rsN equals a same-cycle write-back rd (rsN!=0).
REQ-025 SHALL capture 0 for an unused source operand.
REQ-026 SHALL hold all output-register fields stable while decode_o_valid && !execute_i_ready.
REQ-027 SHALL clear decode_o_valid on output fire without new accept; back-to-back accept+fire every cycle SHALL sustain throughput 1.
REQ-028 SHALL on flush_i clear decode_o_valid next edge, accept nothing that cycle, leave scoreboard untouched (no set for flushed instruction).

Reset
REQ-029 SHALL on rst clear decode_o_valid, all busy bits, and zero decode_o_pc/instr/valA/valB/rd/reg_wen; rst has priority over flush_i and all handshakes.
REQ-030 SHALL drive decode_o_ready=0 while rst=1.

Verification
REQ-031 Reset mid-stall: busy[5]=1, instr reads x5 stalled, assert rst one cycle -> next cycle decode_o_valid=0, busy all 0, same instr accepted.
REQ-032 Forwarding: wb writes x3=0xDEAD same cycle ADD x4,x3,x3 offered, regfile returns old 0x1 -> decode_o_valA=decode_o_valB=0xDEAD one cycle later.
REQ-033 RAW stall: ADDI x1 fired to execute, then ADD x2,x1,x0 offered -> decode_o_ready=0 until wb writes x1, accepted same cycle with forwarded data.
REQ-034 Backpressure: execute_i_ready=0 four cycles with valid output -> all outputs stable, decode_o_ready=0; ready returns 1 on release cycle.
REQ-035 Flush: output holds ADDI x7, flush_i=1 -> decode_o_valid=0 next cycle, busy[7]=0, following ADD x8,x7,x0 not stalled.
REQ-036 x0/store: SW x0,0(x0) and ADDI x0,x0,1 streamed -> decode_o_reg_wen=0, no scoreboard bits set, no stalls, one instruction per cycle.
